// File: rtl/digipot_pkg.sv
// -----------------------------------------------------------------------------
// digipot_pkg
// Shared definitions for the digipot write scheduler:
//   - state_t     : scheduler FSM state encoding (IDLE, SETUP, XFER, GAP)
//   - NUM_POTS    : number of potentiometer channels / requesters
//   - MUX_POTn    : serializer mux codes for each pot
//   - CTRL_ACTIVE : level of the serializer ctrl line while a frame is active
//   - rr_next()   : next pot index in round-robin order (2 wraps to 0)
// -----------------------------------------------------------------------------
package digipot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int NUM_POTS = 3;

   localparam logic [1:0] MUX_POT0 = 2'd0;
   localparam logic [1:0] MUX_POT1 = 2'd1;
   localparam logic [1:0] MUX_POT2 = 2'd2;

   localparam logic CTRL_ACTIVE = 1'b0;

   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == MUX_POT2) ? MUX_POT0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/digipot_scheduler_rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Three-way round-robin arbiter. The pointer holds the most recently granted
// index; the search starts one above it and wraps 2 -> 0, so the last winner
// has the lowest priority on the next arbitration.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset (pointer -> 2)
//   req[2:0]       : request vector
//   grant_en       : commit the current winner into the pointer
//   gnt[2:0]       : one-hot winner (zero when no request)
//   gnt_idx[1:0]   : encoded winner
//   gnt_valid      : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter3
   import digipot_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic       grant_en,
   output logic [2:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   logic [1:0] ptr_q, ptr_d;
   logic [1:0] cand1, cand2;

   always_comb begin
      cand1     = rr_next(ptr_q);
      cand2     = rr_next(cand1);
      gnt_idx   = ptr_q;
      gnt_valid = |req;
      if (req[cand1])
         gnt_idx = cand1;
      else if (req[cand2])
         gnt_idx = cand2;
      else
         gnt_idx = ptr_q;
      gnt = gnt_valid ? (3'b001 << gnt_idx) : 3'b000;
      ptr_d = grant_en ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr_q <= MUX_POT2;
      else
         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/digipot_scheduler.sv
// -----------------------------------------------------------------------------
// digipot_scheduler
// Shares one three-channel SPI digipot serializer between three write
// requesters. Arbitrates round-robin, latches the winner's value and drives
// the serializer with a setup cycle, an XFER_CYCLES-long active-low ctrl
// window and a GAP_CYCLES inter-frame gap.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   req[2:0]           : level write request per pot
//   wdata0..2[7:0]     : value to write to each pot
//   ack[2:0]           : one-cycle one-hot accept pulse
//   mux_o[1:0]         : serializer channel select
//   dato_o[7:0]        : serializer data
//   ctrl_o             : serializer frame enable, active low
//   busy               : scheduler not in IDLE
// Build option:
//   DIGIPOT_SKIP_SAME_EN : when defined, a write whose value matches the last
//                          value framed to that pot is acked without a frame.
// -----------------------------------------------------------------------------
module digipot_scheduler
   import digipot_pkg::*;
#(
   parameter int XFER_CYCLES = 40,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   input  logic [7:0] wdata2,
   output logic [2:0] ack,
   output logic [1:0] mux_o,
   output logic [7:0] dato_o,
   output logic       ctrl_o,
   output logic       busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       mux_q, mux_d;
   logic [7:0]       dato_q, dato_d;
   logic [2:0]       ack_q, ack_d;

   logic [2:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       grant_fire;
   logic       skip;
   logic [7:0] win_data;

   // Arbitration is held off while an ack is still visible: after a skipped
   // write the requester only drops req in the following cycle, and that
   // stale request must not be taken as a new write.
   assign grant_fire = (state_q == ST_IDLE) && gnt_valid && (ack_q == 3'b000);

   rr_arbiter3 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant_en  (grant_fire),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      case (gnt_idx)
         MUX_POT1: win_data = wdata1;
         MUX_POT2: win_data = wdata2;
         default:  win_data = wdata0;
      endcase
   end

`ifdef DIGIPOT_SKIP_SAME_EN
   logic [7:0] shadow_q [NUM_POTS];
   logic [7:0] shadow_d [NUM_POTS];
   logic [2:0] valid_q, valid_d;

   assign skip = valid_q[gnt_idx] && (win_data == shadow_q[gnt_idx]);

   always_comb begin
      shadow_d = shadow_q;
      valid_d  = valid_q;
      if (grant_fire && !skip) begin
         shadow_d[gnt_idx] = win_data;
         valid_d[gnt_idx]  = 1'b1;
      end
   end

   // Shadow contents are meaningless until their valid bit is set, so only
   // the valid bits are reset.
   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
      if (!rst_n)
         valid_q <= 3'b000;
      else
         valid_q <= valid_d;
   end
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      mux_d   = mux_q;
      dato_d  = dato_q;
      ack_d   = 3'b000;
      case (state_q)
         ST_IDLE: begin
            if (grant_fire) begin
               ack_d = gnt;
               if (!skip) begin
                  mux_d   = gnt_idx;
                  dato_d  = win_data;
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            timer_d = CNT_W'(XFER_CYCLES - 1);
            state_d = ST_XFER;
         end
         ST_XFER: begin
            if (timer_q == '0) begin
               timer_d = CNT_W'(GAP_CYCLES - 1);
               state_d = ST_GAP;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (timer_q == '0)
               state_d = ST_IDLE;
            else
               timer_d = timer_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         mux_q   <= MUX_POT0;
         dato_q  <= 8'h00;
         ack_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         mux_q   <= mux_d;
         dato_q  <= dato_d;
         ack_q   <= ack_d;
      end
   end

   assign ack    = ack_q;
   assign mux_o  = mux_q;
   assign dato_o = dato_q;
   assign ctrl_o = (state_q == ST_XFER) ? CTRL_ACTIVE : ~CTRL_ACTIVE;
   assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_digipot_scheduler.sv
module tb_digipot_scheduler;

   localparam int XFER    = 40;
   localparam int GAP     = 4;
   localparam int SPACING = 1 + 1 + XFER + GAP;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic [7:0] wdata0, wdata1, wdata2;
   logic [2:0] ack;
   logic [1:0] mux_o;
   logic [7:0] dato_o;
   logic       ctrl_o, busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle_cnt    = 0;

   digipot_scheduler #(.XFER_CYCLES(XFER), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .wdata2 (wdata2),
      .ack    (ack),
      .mux_o  (mux_o),
      .dato_o (dato_o),
      .ctrl_o (ctrl_o),
      .busy   (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt++;

   // ---------------- reference model ----------------
   // Service order queue: front = highest priority. A grant rotates the queue
   // so that the winner moves to the back.
   int         rr_m[$];
   bit         valid_m [3];
   logic [7:0] shadow_m [3];
   logic [1:0] last_mux_m;
   logic [7:0] last_dato_m;

   task automatic model_reset();
      rr_m = '{0, 1, 2};
      for (int i = 0; i < 3; i++) begin
         valid_m[i]  = 1'b0;
         shadow_m[i] = 8'h00;
      end
      last_mux_m  = 2'd0;
      last_dato_m = 8'h00;
   endtask

   function automatic int model_winner(input logic [2:0] r);
      foreach (rr_m[i]) if (r[rr_m[i]]) return rr_m[i];
      return -1;
   endfunction

   function automatic logic [7:0] wd(input int i);
      case (i)
         0:       return wdata0;
         1:       return wdata1;
         default: return wdata2;
      endcase
   endfunction

   task automatic model_write(input int g, input logic [7:0] d, output bit skipped);
      int x;
      do begin
         x = rr_m.pop_front();
         rr_m.push_back(x);
      end while (x != g);
      skipped = 1'b0;
`ifdef DIGIPOT_SKIP_SAME_EN
      skipped = valid_m[g] && (shadow_m[g] == d);
`endif
      if (!skipped) begin
         valid_m[g]  = 1'b1;
         shadow_m[g] = d;
         last_mux_m  = 2'(g);
         last_dato_m = d;
      end
   endtask

   // ---------------- observation helpers (measure only) ----------------
   task automatic apply_reset();
      rst_n = 1'b0; req = 3'b000;
      wdata0 = 8'h00; wdata1 = 8'h00; wdata2 = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic wait_ack(output logic [2:0] a, output int at, output bit to);
      a = 3'b000; at = 0; to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ack !== 3'b000) begin
            a = ack; at = cycle_cnt; to = 1'b0;
            break;
         end
      end
   endtask

   // Runs from the SETUP sample until the first IDLE sample.
   task automatic observe_frame(output int low_cnt, output int gap_cnt, output bit held,
                                output int extra_acks, output bit to);
      logic [1:0] m0;
      logic [7:0] d0;
      m0 = mux_o; d0 = dato_o;
      low_cnt = 0; gap_cnt = 0; held = 1'b1; extra_acks = 0; to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mux_o !== m0 || dato_o !== d0) held = 1'b0;
         if (ack !== 3'b000) extra_acks++;
         if (ctrl_o === 1'b0) low_cnt++;
         else if (busy === 1'b1) gap_cnt++;
         else begin
            to = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      tests_run++; if (ctrl_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ctrl: got %b want 1", ctrl_o); end
      tests_run++; if (mux_o !== 2'd0) begin tests_failed++; $display("FAIL reset_mux: got %0d want 0", mux_o); end
      tests_run++; if (dato_o !== 8'h00) begin tests_failed++; $display("FAIL reset_dato: got %h want 00", dato_o); end
      tests_run++; if (ack !== 3'b000) begin tests_failed++; $display("FAIL reset_ack: got %b want 000", ack); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      $display("[TB] reset: ctrl=%b mux=%0d dato=%h ack=%b busy=%b", ctrl_o, mux_o, dato_o, ack, busy);
   endtask

   task automatic test_single();
      logic [2:0] a; int at, lo, gp, ex; bit to, held, sk; int g;
      apply_reset();
      wdata1 = 8'h55; req = 3'b010;
      g = model_winner(req);
      wait_ack(a, at, to);
      tests_run++; if (to) begin tests_failed++; $display("FAIL single_timeout: no ack got none want ack"); end
      tests_run++; if (a !== 3'(1 << g)) begin tests_failed++; $display("FAIL single_ack: got %b want %b", a, 3'(1 << g)); end
      tests_run++; if (mux_o !== 2'd1) begin tests_failed++; $display("FAIL single_mux: got %0d want 1", mux_o); end
      tests_run++; if (dato_o !== 8'h55) begin tests_failed++; $display("FAIL single_dato: got %h want 55", dato_o); end
      tests_run++; if (ctrl_o !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_setup: got ctrl=%b busy=%b want ctrl=1 busy=1", ctrl_o, busy); end
      model_write(g, 8'h55, sk);
      req = 3'b000;
      observe_frame(lo, gp, held, ex, to);
      tests_run++; if (lo != XFER) begin tests_failed++; $display("FAIL single_low: got %0d want %0d", lo, XFER); end
      tests_run++; if (gp != GAP || to) begin tests_failed++; $display("FAIL single_gap: got %0d (timeout %0b) want %0d", gp, to, GAP); end
      tests_run++; if (!held || ex != 0) begin tests_failed++; $display("FAIL single_hold: got held=%0b extra_acks=%0d want held=1 extra_acks=0", held, ex); end
      $display("[TB] single: ack=%b mux=%0d dato=%h low=%0d gap=%0d", a, mux_o, dato_o, lo, gp);
   endtask

   task automatic test_round_robin();
      logic [2:0] a; int at, prev_at, lo, gp, ex, g; bit to, held, sk;
      apply_reset();
      wdata0 = 8'hA0; wdata1 = 8'hA1; wdata2 = 8'hA2; req = 3'b111;
      prev_at = -1;
      for (int k = 0; k < 3; k++) begin
         g = model_winner(req);
         wait_ack(a, at, to);
         tests_run++; if (a !== 3'(1 << g) || to) begin tests_failed++; $display("FAIL rr_ack%0d: got %b want %b", k, a, 3'(1 << g)); end
         tests_run++; if (mux_o !== 2'(g) || dato_o !== wd(g)) begin tests_failed++; $display("FAIL rr_data%0d: got mux=%0d dato=%h want mux=%0d dato=%h", k, mux_o, dato_o, g, wd(g)); end
         if (prev_at >= 0) begin
            tests_run++; if (at - prev_at != SPACING) begin tests_failed++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, at - prev_at, SPACING); end
         end
         prev_at = at;
         model_write(g, wd(g), sk);
         req[g] = 1'b0;
         observe_frame(lo, gp, held, ex, to);
         tests_run++; if (lo != XFER || !held) begin tests_failed++; $display("FAIL rr_frame%0d: got low=%0d held=%0b want low=%0d held=1", k, lo, held, XFER); end
         $display("[TB] rr: grant pot%0d ack=%b mux=%0d dato=%h low=%0d", g, a, mux_o, dato_o, lo);
      end
   endtask

   task automatic test_alternate();
      logic [2:0] a; int at, lo, gp, ex, g; bit to, held, sk;
      apply_reset();
      wdata0 = 8'h10; wdata2 = 8'h20; req = 3'b101;
      for (int k = 0; k < 4; k++) begin
         g = model_winner(req);
         wait_ack(a, at, to);
         tests_run++; if (a !== 3'(1 << g) || to) begin tests_failed++; $display("FAIL alt_ack%0d: got %b want %b", k, a, 3'(1 << g)); end
         tests_run++; if (dato_o !== wd(g)) begin tests_failed++; $display("FAIL alt_dato%0d: got %h want %h", k, dato_o, wd(g)); end
         model_write(g, wd(g), sk);
         // Level request stays high: the next IDLE sees a fresh write.
         if (g == 0) wdata0 = wdata0 + 8'd1; else wdata2 = wdata2 + 8'd1;
         observe_frame(lo, gp, held, ex, to);
         $display("[TB] alternate: grant pot%0d ack=%b low=%0d", g, a, lo);
      end
      req = 3'b000;
   endtask

   task automatic test_reset_midframe();
      logic [2:0] a; int at, lo, gp, ex, g; bit to, held, sk;
      apply_reset();
      wdata1 = 8'h33; req = 3'b010;
      g = model_winner(req);
      wait_ack(a, at, to);
      model_write(g, 8'h33, sk);
      req = 3'b000;
      repeat (20) @(negedge clk);
      tests_run++; if (ctrl_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_inxfer: got ctrl=%b want 0", ctrl_o); end
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++; if (ctrl_o !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_ctrl_busy: got ctrl=%b busy=%b want ctrl=1 busy=0", ctrl_o, busy); end
      tests_run++; if (mux_o !== 2'd0 || dato_o !== 8'h00) begin tests_failed++; $display("FAIL midrst_mux_dato: got mux=%0d dato=%h want mux=0 dato=00", mux_o, dato_o); end
      tests_run++; if (ack !== 3'b000) begin tests_failed++; $display("FAIL midrst_ack: got %b want 000", ack); end
      rst_n = 1'b1;
      model_reset();
      wdata0 = 8'h44; wdata2 = 8'h66; req = 3'b101;
      for (int k = 0; k < 2; k++) begin
         g = model_winner(req);
         wait_ack(a, at, to);
         tests_run++; if (a !== 3'(1 << g) || dato_o !== wd(g) || to) begin tests_failed++; $display("FAIL midrst_next%0d: got ack=%b dato=%h want ack=%b dato=%h", k, a, dato_o, 3'(1 << g), wd(g)); end
         model_write(g, wd(g), sk);
         req[g] = 1'b0;
         observe_frame(lo, gp, held, ex, to);
         $display("[TB] reset_midframe: grant pot%0d ack=%b dato=%h", g, a, dato_o);
      end
   endtask

   task automatic test_data_hold();
      logic [2:0] a; int at, lo, gp, ex, g; bit to, held, sk;
      apply_reset();
      wdata0 = 8'h11; req = 3'b001;
      g = model_winner(req);
      wait_ack(a, at, to);
      model_write(g, 8'h11, sk);
      req = 3'b000;
      repeat (10) @(negedge clk);
      wdata0 = 8'h22;
      observe_frame(lo, gp, held, ex, to);
      tests_run++; if (!held || dato_o !== 8'h11) begin tests_failed++; $display("FAIL hold_dato: got held=%0b dato=%h want held=1 dato=11", held, dato_o); end
      req = 3'b001;
      g = model_winner(req);
      wait_ack(a, at, to);
      tests_run++; if (a !== 3'(1 << g) || dato_o !== 8'h22 || to) begin tests_failed++; $display("FAIL hold_next: got ack=%b dato=%h want ack=%b dato=22", a, dato_o, 3'(1 << g)); end
      model_write(g, 8'h22, sk);
      req = 3'b000;
      observe_frame(lo, gp, held, ex, to);
      $display("[TB] data_hold: held=%0b second dato=%h", held, dato_o);
   endtask

`ifdef DIGIPOT_SKIP_SAME_EN
   task automatic test_skip_same();
      logic [2:0] a; int at, lo, gp, ex, g, lows, busys, acks; bit to, held, sk;
      apply_reset();
      wdata2 = 8'h7F; req = 3'b100;
      g = model_winner(req);
      wait_ack(a, at, to);
      model_write(g, 8'h7F, sk);
      req = 3'b000;
      observe_frame(lo, gp, held, ex, to);
      tests_run++; if (lo != XFER) begin tests_failed++; $display("FAIL skip_first: got low=%0d want %0d", lo, XFER); end
      req = 3'b100;
      g = model_winner(req);
      wait_ack(a, at, to);
      model_write(g, 8'h7F, sk);
      tests_run++; if (a !== 3'b100 || busy !== 1'b0 || to) begin tests_failed++; $display("FAIL skip_ack: got ack=%b busy=%b want ack=100 busy=0", a, busy); end
      @(negedge clk);
      req = 3'b000;
      lows = 0; busys = 0; acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ctrl_o !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
         if (ack !== 3'b000) acks++;
      end
      tests_run++; if (lows != 0 || busys != 0 || acks != 0) begin tests_failed++; $display("FAIL skip_quiet: got lows=%0d busys=%0d acks=%0d want 0 0 0", lows, busys, acks); end
      tests_run++; if (mux_o !== last_mux_m || dato_o !== last_dato_m) begin tests_failed++; $display("FAIL skip_mux_dato: got mux=%0d dato=%h want mux=%0d dato=%h", mux_o, dato_o, last_mux_m, last_dato_m); end
      wdata2 = 8'h80; req = 3'b100;
      g = model_winner(req);
      wait_ack(a, at, to);
      model_write(g, 8'h80, sk);
      req = 3'b000;
      tests_run++; if (busy !== 1'b1 || dato_o !== 8'h80) begin tests_failed++; $display("FAIL skip_third: got busy=%b dato=%h want busy=1 dato=80", busy, dato_o); end
      observe_frame(lo, gp, held, ex, to);
      tests_run++; if (lo != XFER) begin tests_failed++; $display("FAIL skip_third_low: got %0d want %0d", lo, XFER); end
      $display("[TB] skip_same: third write low=%0d dato=%h", lo, dato_o);
   endtask
`endif

   task automatic test_random();
      logic [2:0] a; int at, lo, gp, ex, g; bit to, held, sk;
      logic [7:0] d;
      apply_reset();
      for (int r = 0; r < 6; r++) begin
         wdata0 = 8'($urandom); wdata1 = 8'($urandom); wdata2 = 8'($urandom);
         req = 3'($urandom_range(1, 7));
         while (req != 3'b000) begin
            g = model_winner(req);
            d = wd(g);
            wait_ack(a, at, to);
            tests_run++; if (a !== 3'(1 << g) || to) begin tests_failed++; $display("FAIL rand_ack: got %b want %b", a, 3'(1 << g)); end
            if (to) begin
               req = 3'b000;
               break;
            end
            model_write(g, d, sk);
            req[g] = 1'b0;
            if (sk) begin
               tests_run++; if (busy !== 1'b0 || dato_o !== last_dato_m) begin tests_failed++; $display("FAIL rand_skip: got busy=%b dato=%h want busy=0 dato=%h", busy, dato_o, last_dato_m); end
               $display("[TB] random: pot%0d skipped dato=%h", g, d);
            end else begin
               tests_run++; if (mux_o !== last_mux_m || dato_o !== last_dato_m) begin tests_failed++; $display("FAIL rand_data: got mux=%0d dato=%h want mux=%0d dato=%h", mux_o, dato_o, last_mux_m, last_dato_m); end
               observe_frame(lo, gp, held, ex, to);
               tests_run++; if (lo != XFER || gp != GAP || !held) begin tests_failed++; $display("FAIL rand_frame: got low=%0d gap=%0d held=%0b want %0d %0d 1", lo, gp, held, XFER, GAP); end
               $display("[TB] random: pot%0d ack=%b dato=%h low=%0d gap=%0d", g, a, dato_o, lo, gp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_alternate();
      test_reset_midframe();
      test_data_hold();
`ifdef DIGIPOT_SKIP_SAME_EN
      test_skip_same();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
